// File: rtl/hsv_core_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hsv_core_flush_ctrl
// Description : Central flush sequencer. Broadcasts a flush request and
//               redirect target to all pipeline units, collects their
//               acknowledges, pulses completion, and optionally parks the
//               core in a halted state until resume or a new flush.
// Revision    : 1.0 - initial release
// ============================================================================
module hsv_core_flush_ctrl #(
  parameter int          NUM_UNITS      = 8,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] RESET_TARGET   = 32'h0000_0000
) (
  input  logic                 clk_core,
  input  logic                 rst_core_n,
  input  logic                 flush_begin,
  input  logic [31:0]          flush_target_i,
  input  logic                 flush_halt_i,
  input  logic                 resume,
  input  logic [NUM_UNITS-1:0] flush_ack,
  output logic                 flush_req,
  output logic [31:0]          flush_target,
  output logic                 flush_halt,
  output logic                 busy,
  output logic                 halted,
  output logic                 flush_done,
  output logic                 timeout_err
);

  // Counter only has to reach TIMEOUT_CYCLES-1, where it saturates.
  localparam int          CW        = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] C_CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_DONE   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   w_accept;
  logic                   w_all_acked;
  logic [NUM_UNITS-1:0]   r_ack_seen;
  logic [CW-1:0]          r_cnt;
  logic [31:0]            r_target;
  logic                   r_halt;
  logic                   r_timeout;
  logic                   r_flush_req;
  logic                   r_busy;
  logic                   r_halted;
  logic                   r_flush_done;

  // An acknowledge arriving in the current cycle completes the set immediately.
  assign w_all_acked = &(r_ack_seen | flush_ack);

  // Next-state selection; flush_begin outranks resume while halted.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (flush_begin) begin
          w_next_state = S_REQ;
          w_accept     = 1'b1;
        end
      end
      S_REQ: begin
        if (w_all_acked) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = r_halt ? S_HALTED : S_IDLE;
      end
      S_HALTED: begin
        if (flush_begin) begin
          w_next_state = S_REQ;
          w_accept     = 1'b1;
        end else if (resume) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register; status outputs are registered from the next state so
  // they line up with the state and have no input-to-output path.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_state      <= S_IDLE;
      r_flush_req  <= 1'b0;
      r_busy       <= 1'b0;
      r_halted     <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_flush_req  <= (w_next_state == S_REQ);
      r_busy       <= (w_next_state != S_IDLE);
      r_halted     <= (w_next_state == S_HALTED);
      r_flush_done <= (w_next_state == S_DONE);
    end
  end

  // Command latch, acknowledge collection and timeout watchdog.
  always_ff @(posedge clk_core or negedge rst_core_n) begin
    if (!rst_core_n) begin
      r_target   <= RESET_TARGET;
      r_halt     <= 1'b0;
      r_ack_seen <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
    end else if (w_accept) begin
      r_target   <= flush_target_i;
      r_halt     <= flush_halt_i;
      r_ack_seen <= '0;
      r_cnt      <= '0;
      r_timeout  <= 1'b0;
    end else if (r_state == S_REQ) begin
      r_ack_seen <= r_ack_seen | flush_ack;
      if (r_cnt != C_CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      // Sticky; the flush keeps waiting after a timeout.
      if ((r_cnt == C_CNT_MAX) && !w_all_acked) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign flush_req    = r_flush_req;
  assign flush_target = r_target;
  assign flush_halt   = r_halt;
  assign busy         = r_busy;
  assign halted       = r_halted;
  assign flush_done   = r_flush_done;
  assign timeout_err  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_hsv_core_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hsv_core_flush_ctrl
// Description : Self-checking bench for hsv_core_flush_ctrl. A behavioural
//               model tracks the pending flush; a scoreboard queue holds the
//               expected completion of each accepted flush and a monitor
//               checks it whenever flush_done is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hsv_core_flush_ctrl;

  localparam int NU = 8;
  localparam int TO = 16;

  logic          clk_core = 1'b0;
  logic          rst_core_n = 1'b0;
  logic          flush_begin = 1'b0;
  logic [31:0]   flush_target_i = '0;
  logic          flush_halt_i = 1'b0;
  logic          resume = 1'b0;
  logic [NU-1:0] flush_ack = '0;
  logic          flush_req;
  logic [31:0]   flush_target;
  logic          flush_halt;
  logic          busy;
  logic          halted;
  logic          flush_done;
  logic          timeout_err;

  hsv_core_flush_ctrl #(
    .NUM_UNITS      (NU),
    .TIMEOUT_CYCLES (TO),
    .RESET_TARGET   (32'h0000_0000)
  ) dut (
    .clk_core       (clk_core),
    .rst_core_n     (rst_core_n),
    .flush_begin    (flush_begin),
    .flush_target_i (flush_target_i),
    .flush_halt_i   (flush_halt_i),
    .resume         (resume),
    .flush_ack      (flush_ack),
    .flush_req      (flush_req),
    .flush_target   (flush_target),
    .flush_halt     (flush_halt),
    .busy           (busy),
    .halted         (halted),
    .flush_done     (flush_done),
    .timeout_err    (timeout_err)
  );

  always #5 clk_core = ~clk_core;

  typedef struct {
    logic [31:0] tgt;
    logic        hlt;
  } exp_t;
  exp_t sb_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: what the controller is doing in spec terms.
  // activity: 0 = nothing pending, 1 = waiting for acks, 2 = completion cycle,
  // 3 = parked.
  int            m_act;
  logic [31:0]   m_tgt;
  logic          m_halt;
  logic [NU-1:0] m_seen;
  int            m_wait;
  logic          m_tout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_act  = 0;
    m_tgt  = 32'h0;
    m_halt = 1'b0;
    m_seen = '0;
    m_wait = 0;
    m_tout = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_accept(input logic [31:0] tgt, input logic hlt);
    exp_t e;
    m_act  = 1;
    m_tgt  = tgt;
    m_halt = hlt;
    m_seen = '0;
    m_wait = 0;
    m_tout = 1'b0;
    e.tgt  = tgt;
    e.hlt  = hlt;
    sb_q.push_back(e);
  endtask

  // Effect of one clock edge with the given inputs.
  task automatic model_step(input logic fb, input logic [31:0] tgt, input logic hlt,
                            input logic res, input logic [NU-1:0] ack);
    case (m_act)
      0: if (fb) model_accept(tgt, hlt);
      1: begin
        m_seen = m_seen | ack;
        m_wait = m_wait + 1;
        if (m_seen == {NU{1'b1}}) m_act = 2;
        else if (m_wait >= TO) m_tout = 1'b1;
      end
      2: m_act = m_halt ? 3 : 0;
      default: begin
        if (fb) model_accept(tgt, hlt);
        else if (res) m_act = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    chk("flush_req",    32'(flush_req),   32'(m_act == 1));
    chk("busy",         32'(busy),        32'(m_act != 0));
    chk("halted",       32'(halted),      32'(m_act == 3));
    chk("flush_done",   32'(flush_done),  32'(m_act == 2));
    chk("flush_target", flush_target,     m_tgt);
    chk("flush_halt",   32'(flush_halt),  32'(m_halt));
    chk("timeout_err",  32'(timeout_err), 32'(m_tout));
  endtask

  // Apply inputs for one cycle (called at a negedge), then check at next negedge.
  task automatic cycle(input logic fb, input logic [31:0] tgt, input logic hlt,
                       input logic res, input logic [NU-1:0] ack);
    flush_begin    = fb;
    flush_target_i = tgt;
    flush_halt_i   = hlt;
    resume         = res;
    flush_ack      = ack;
    model_step(fb, tgt, hlt, res, ack);
    @(posedge clk_core);
    @(negedge clk_core);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: every flush_done must match the oldest accepted flush.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_core);
      if (rst_core_n && flush_done === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL done_unexpected: flush_done=1 with no flush pending at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("done_target", flush_target, e.tgt);
          chk("done_halt",   32'(flush_halt), 32'(e.hlt));
        end
      end
    end
  end

  initial begin
    model_reset();
    // Reset state
    rst_core_n = 1'b0;
    repeat (3) @(negedge clk_core);
    check_outputs();
    rst_core_n = 1'b1;
    idle(2);

    // Basic flush: acks all at cycle 3
    cycle(1'b1, 32'h8000_0100, 1'b0, 1'b0, '0);
    idle(2);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, '1);
    idle(3);

    // Staggered pulse acks
    cycle(1'b1, 32'h0000_1000, 1'b0, 1'b0, '0);
    for (int i = 0; i < NU; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, NU'(1) << i);
    idle(2);

    // Withhold bit 5 long enough to time out, then ack it
    cycle(1'b1, 32'h0000_2000, 1'b0, 1'b0, '0);
    for (int i = 0; i < NU; i++)
      cycle(1'b0, 32'h0, 1'b0, 1'b0, (i == 5) ? NU'(0) : (NU'(1) << i));
    idle(12);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, NU'(1) << 5);
    idle(3);

    // Halt, resume
    cycle(1'b1, 32'h0000_3000, 1'b1, 1'b0, '0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, '1);
    idle(3);
    cycle(1'b0, 32'h0, 1'b0, 1'b1, '0);
    idle(2);

    // Halt, then flush_begin and resume together
    cycle(1'b1, 32'h0000_3100, 1'b1, 1'b0, '1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, '1);
    idle(2);
    cycle(1'b1, 32'h0000_0040, 1'b0, 1'b1, '0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, '1);
    idle(2);

    // Busy collision: second command during REQ ignored
    cycle(1'b1, 32'h0000_5000, 1'b0, 1'b0, '0);
    cycle(1'b1, 32'hDEAD_BEE0, 1'b1, 1'b0, 8'h0F);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 8'hF0);
    cycle(1'b1, 32'hDEAD_BEE0, 1'b0, 1'b0, '0);
    idle(2);

    // Async reset mid-REQ
    cycle(1'b1, 32'h0000_6000, 1'b0, 1'b0, '0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 8'h03);
    #2 rst_core_n = 1'b0;
    #1;
    chk("async_rst_flush_req", 32'(flush_req), 32'h0);
    chk("async_rst_busy",      32'(busy),      32'h0);
    model_reset();
    @(negedge clk_core);
    rst_core_n = 1'b1;
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 4) == 0), $urandom, 1'(($urandom_range(0, 2) == 0)),
            ($urandom_range(0, 3) == 0), NU'($urandom & $urandom));
    end
    idle(2 * TO);

    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d completions outstanding, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
